// File: rtl/posit_div_arbiter.sv
// Round-robin sharing of one fixed-latency posit divider among NUM_REQ requesters,
// with in-order ID tagging and a credit-protected result FIFO. Define POSIT_DIV_ARB_PERF_EN for perf counters.
module posit_div_arbiter #(
    parameter int N         = 16,
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int DIV_LAT   = 12,
    parameter int RSP_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*N-1:0] req_a,
    input  logic [NUM_REQ*N-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [N-1:0]         rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 rsp_inf,
    output logic                 rsp_zero,
    output logic                 div_start,
    output logic [N-1:0]         div_in1,
    output logic [N-1:0]         div_in2,
    input  logic [N-1:0]         div_out,
    input  logic                 div_inf,
    input  logic                 div_zero,
    input  logic                 div_done,
    output logic                 err_orphan
`ifdef POSIT_DIV_ARB_PERF_EN
    ,
    output logic [31:0]          perf_issue,
    output logic [31:0]          perf_stall
`endif
);
    localparam int AW = $clog2(RSP_DEPTH);
    localparam int CW = $clog2(DIV_LAT + 1);
    localparam int PW = ID_W + 1;
    localparam int NP = 2 ** ID_W;

    typedef enum logic {BLANK, RUN} state_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [N-1:0]    data;
        logic            inf;
        logic            zero;
    } res_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   blank_cnt;
    logic [ID_W-1:0] rr_ptr, grant_idx;
    logic [PW-1:0]   cand;
    logic [NP-1:0]   valid_pad;
    logic            grant_found, credit_ok, issue;
    logic [N-1:0]    sel_a, sel_b;
    logic [AW:0]     outstanding;

    logic [ID_W-1:0] id_mem [RSP_DEPTH];
    logic [AW-1:0]   id_wr, id_rd;
    logic [AW:0]     id_cnt;
    logic            done_run, id_pop;

    res_t            res_mem [RSP_DEPTH];
    res_t            res_head;
    logic [AW-1:0]   res_wr, res_rd;
    logic [AW:0]     res_cnt;
    logic            res_push, res_pop;

    // BLANK lasts DIV_LAT+1 cycles so every pre-reset divider result drains unseen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BLANK;
            blank_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == BLANK)
                blank_cnt <= blank_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == BLANK && blank_cnt == CW'(DIV_LAT))
            state_nxt = RUN;
    end

    assign valid_pad = NP'(req_valid);

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PW'(rr_ptr) + PW'(k);
            if (cand >= PW'(NUM_REQ))
                cand = cand - PW'(NUM_REQ);
            if (!grant_found && valid_pad[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    assign credit_ok = outstanding < (AW+1)'(RSP_DEPTH);
    assign issue     = (state == RUN) && grant_found && credit_ok;

    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_idx == ID_W'(j)) begin
                req_ready[j] = issue;
                sel_a        = req_a[j*N +: N];
                sel_b        = req_b[j*N +: N];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_start <= 1'b0;
            div_in1   <= '0;
            div_in2   <= '0;
            rr_ptr    <= '0;
        end else begin
            div_start <= issue;
            if (issue) begin
                div_in1 <= sel_a;
                div_in2 <= sel_b;
                rr_ptr  <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // The ID FIFO cannot overflow: its occupancy never exceeds outstanding.
    assign done_run = (state == RUN) && div_done;
    assign id_pop   = done_run && (id_cnt != '0);
    assign res_push = id_pop;
    assign res_pop  = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (issue)
            id_mem[id_wr] <= grant_idx;
        if (res_push)
            res_mem[res_wr] <= '{id: id_mem[id_rd], data: div_out, inf: div_inf, zero: div_zero};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_wr       <= '0;
            id_rd       <= '0;
            id_cnt      <= '0;
            res_wr      <= '0;
            res_rd      <= '0;
            res_cnt     <= '0;
            outstanding <= '0;
            err_orphan  <= 1'b0;
        end else begin
            if (issue)
                id_wr <= id_wr + 1'b1;
            if (id_pop)
                id_rd <= id_rd + 1'b1;
            id_cnt <= id_cnt + (AW+1)'(issue) - (AW+1)'(id_pop);
            if (res_push)
                res_wr <= res_wr + 1'b1;
            if (res_pop)
                res_rd <= res_rd + 1'b1;
            res_cnt     <= res_cnt + (AW+1)'(res_push) - (AW+1)'(res_pop);
            outstanding <= outstanding + (AW+1)'(issue) - (AW+1)'(res_pop);
            if (done_run && id_cnt == '0)
                err_orphan <= 1'b1;
        end
    end

    // Outputs read zero while empty so they match the reset values.
    assign res_head  = res_mem[res_rd];
    assign rsp_valid = (res_cnt != '0);
    assign rsp_data  = rsp_valid ? res_head.data : '0;
    assign rsp_id    = rsp_valid ? res_head.id   : '0;
    assign rsp_inf   = rsp_valid && res_head.inf;
    assign rsp_zero  = rsp_valid && res_head.zero;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst)
            assert (!(res_push && res_cnt == (AW+1)'(RSP_DEPTH)));
    end
`endif

`ifdef POSIT_DIV_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue <= '0;
            perf_stall <= '0;
        end else begin
            if (issue && perf_issue != '1)
                perf_issue <= perf_issue + 1'b1;
            if (state == RUN && (|req_valid) && req_ready == '0 && perf_stall != '1)
                perf_stall <= perf_stall + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_posit_div_arbiter.sv
// Scoreboard bench for posit_div_arbiter driving a fixed-latency stand-in divider
// with hand-computed quotients for the directed operand pairs.
`timescale 1ns/1ps
module tb_posit_div_arbiter;
    localparam int N         = 16;
    localparam int NUM_REQ   = 4;
    localparam int ID_W      = 2;
    localparam int DIV_LAT   = 12;
    localparam int RSP_DEPTH = 16;

    typedef struct packed {
        logic            v;
        logic [N-1:0]    q;
        logic            inf;
        logic            zero;
    } stage_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [N-1:0]    q;
        logic            inf;
        logic            zero;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*N-1:0] req_a = '0;
    logic [NUM_REQ*N-1:0] req_b = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b1;
    logic [N-1:0]         rsp_data;
    logic [ID_W-1:0]      rsp_id;
    logic                 rsp_inf, rsp_zero;
    logic                 div_start;
    logic [N-1:0]         div_in1, div_in2, div_out;
    logic                 div_inf, div_zero, div_done;
    logic                 err_orphan;
    logic                 force_done = 1'b0;
`ifdef POSIT_DIV_ARB_PERF_EN
    logic [31:0]          perf_issue, perf_stall;
`endif

    int   total = 0;
    int   bad = 0;
    int   since = 0;
    int   issued_cnt = 0;
    int   popped_cnt = 0;
    int   out_model = 0;
    int   mptr = 0;
    int   hs_cnt = 0;
    logic last_issue = 1'b0;
    logic [N-1:0] last_a = '0, last_b = '0;
    logic [NUM_REQ-1:0] exp_ready;
    exp_t exp_res [NUM_REQ];
    exp_t sb [$];
    exp_t push_e, mon_e;
    stage_t pipe [DIV_LAT];

    posit_div_arbiter #(
        .N(N), .NUM_REQ(NUM_REQ), .ID_W(ID_W), .DIV_LAT(DIV_LAT), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .rsp_inf(rsp_inf), .rsp_zero(rsp_zero),
        .div_start(div_start), .div_in1(div_in1), .div_in2(div_in2),
        .div_out(div_out), .div_inf(div_inf), .div_zero(div_zero), .div_done(div_done),
        .err_orphan(err_orphan)
`ifdef POSIT_DIV_ARB_PERF_EN
        , .perf_issue(perf_issue), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in divider: knows only the operand pairs this bench uses.
    function automatic stage_t div_model(input logic [N-1:0] a, input logic [N-1:0] b);
        stage_t r;
        r = '0;
        r.v = 1'b1;
        if (b == '0 || a == 16'h8000 || b == 16'h8000) begin
            r.q = 16'h8000; r.inf = 1'b1;
        end else if (a == '0) r.zero = 1'b1;
        else if (a == b) r.q = 16'h4000;
        else if (a == 16'h6000 && b == 16'h5000) r.q = 16'h5000;
        else r.q = 16'h7fff;
        return r;
    endfunction

    initial for (int i = 0; i < DIV_LAT; i++) pipe[i] = '0;

    always @(posedge clk) begin
        pipe[0] <= (div_start === 1'b1) ? div_model(div_in1, div_in2) : '0;
        for (int i = 1; i < DIV_LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign div_done = pipe[DIV_LAT-1].v | force_done;
    assign div_out  = force_done ? 16'h1234 : pipe[DIV_LAT-1].q;
    assign div_inf  = pipe[DIV_LAT-1].inf;
    assign div_zero = pipe[DIV_LAT-1].zero;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    // Reset bookkeeping and credit snapshot, taken after the previous negedge's updates.
    always @(posedge clk) begin
        if (rst) begin
            since = 0; issued_cnt = 0; popped_cnt = 0; mptr = 0;
            last_issue = 1'b0;
            sb.delete();
        end else if (since < 1000) since++;
        out_model = issued_cnt - popped_cnt;
    end

    // Issue side: predicts grants and credit, pushes expected responses.
    always @(negedge clk) begin
        check_output("div_start", 32'(div_start), 32'(last_issue));
        if (last_issue) begin
            check_output("div_in1", 32'(div_in1), 32'(last_a));
            check_output("div_in2", 32'(div_in2), 32'(last_b));
        end
        exp_ready = '0;
        if (since >= DIV_LAT + 1 && out_model < RSP_DEPTH) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (exp_ready == '0 && req_valid[(mptr + k) % NUM_REQ])
                    exp_ready[(mptr + k) % NUM_REQ] = 1'b1;
            end
        end
        check_output("req_ready", 32'(req_ready), 32'(exp_ready));
        hs_cnt += $countones(req_valid & req_ready);
        last_issue = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (exp_ready[j]) begin
                push_e    = exp_res[j];
                push_e.id = ID_W'(j);
                sb.push_back(push_e);
                issued_cnt++;
                mptr       = (j + 1) % NUM_REQ;
                last_issue = 1'b1;
                last_a     = req_a[j*N +: N];
                last_b     = req_b[j*N +: N];
            end
        end
    end

    // Monitor: every accepted response must match the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1 && rsp_ready) begin
            popped_cnt++;
            if (sb.size() == 0) begin
                total++; bad++;
                $display("[TB] FAIL rsp_unexpected: got id=%0d data=%h, required no response", rsp_id, rsp_data);
            end else begin
                mon_e = sb.pop_front();
                check_output("rsp_id",   32'(rsp_id),   32'(mon_e.id));
                check_output("rsp_data", 32'(rsp_data), 32'(mon_e.q));
                check_output("rsp_inf",  32'(rsp_inf),  32'(mon_e.inf));
                check_output("rsp_zero", 32'(rsp_zero), 32'(mon_e.zero));
            end
        end
    end

    task automatic apply_stimulus(input int j, input logic [N-1:0] a, input logic [N-1:0] b,
                                  input logic [N-1:0] q, input logic inf, input logic zero);
        req_a[j*N +: N] = a;
        req_b[j*N +: N] = b;
        exp_res[j] = '{id: '0, q: q, inf: inf, zero: zero};
    endtask

    task automatic issue_one(input int j);
        int n;
        n = 0;
        req_valid[j] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[j] && n < 50);
        check_output("issue_handshake", 32'(req_ready[j]), 32'd1);
        @(posedge clk); #1;
        req_valid[j] = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int hs0;
        wait_cycles(2);
        @(negedge clk);
        check_output("rst_req_ready",  32'(req_ready),  32'd0);
        check_output("rst_rsp_valid",  32'(rsp_valid),  32'd0);
        check_output("rst_err_orphan", 32'(err_orphan), 32'd0);
        check_output("rst_rsp_data",   32'(rsp_data),   32'd0);
        check_output("rst_rsp_id",     32'(rsp_id),     32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_cycles(DIV_LAT + 2);

        $display("[TB] single op");
        apply_stimulus(0, 16'h6000, 16'h5000, 16'h5000, 1'b0, 1'b0);
        issue_one(0);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (rsp_valid) break;
        end
        check_output("single_latency", 32'(lat), 32'(DIV_LAT + 1));
        wait_cycles(5);

        $display("[TB] round robin");
        for (int j = 0; j < NUM_REQ; j++) apply_stimulus(j, 16'h4000, 16'h4000, 16'h4000, 1'b0, 1'b0);
        req_valid = '1;
        wait_cycles(8);
        req_valid = '0;
        wait_cycles(30);

        $display("[TB] special values");
        apply_stimulus(1, 16'h4000, 16'h0000, 16'h8000, 1'b1, 1'b0);
        issue_one(1);
        apply_stimulus(3, 16'h0000, 16'h5000, 16'h0000, 1'b0, 1'b1);
        issue_one(3);
        wait_cycles(30);

        $display("[TB] backpressure");
        apply_stimulus(0, 16'h6000, 16'h5000, 16'h5000, 1'b0, 1'b0);
        apply_stimulus(1, 16'h4000, 16'h4000, 16'h4000, 1'b0, 1'b0);
        apply_stimulus(2, 16'h4000, 16'h0000, 16'h8000, 1'b1, 1'b0);
        apply_stimulus(3, 16'h0000, 16'h5000, 16'h0000, 1'b0, 1'b1);
        hs0 = hs_cnt;
        rsp_ready = 1'b0;
        req_valid = '1;
        wait_cycles(40);
        @(negedge clk);
        check_output("bp_issue_count", 32'(hs_cnt - hs0), 32'(RSP_DEPTH));
        check_output("bp_req_ready",   32'(req_ready),    32'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_cycles(20);
        req_valid = '0;
        wait_cycles(40);
        check_output("bp_all_delivered", 32'(sb.size()), 32'd0);

        $display("[TB] reset mid-flight");
        for (int j = 0; j < NUM_REQ; j++) apply_stimulus(j, 16'h4000, 16'h4000, 16'h4000, 1'b0, 1'b0);
        req_valid = 4'b0001;
        wait_cycles(5);
        rst = 1'b1;
        req_valid = '1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < DIV_LAT + 1; c++) begin
            @(negedge clk);
            check_output("blank_err_orphan", 32'(err_orphan), 32'd0);
            check_output("blank_rsp_valid",  32'(rsp_valid),  32'd0);
        end
        wait_cycles(4);
        req_valid = '0;
        wait_cycles(40);
        check_output("post_reset_delivered", 32'(sb.size()), 32'd0);

        $display("[TB] orphan");
        check_output("pre_orphan_flag", 32'(err_orphan), 32'd0);
        force_done = 1'b1;
        wait_cycles(1);
        force_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_output("orphan_flag",      32'(err_orphan), 32'd1);
            check_output("orphan_rsp_valid", 32'(rsp_valid),  32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        @(negedge clk);
        check_output("orphan_cleared", 32'(err_orphan), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, required finish before 200000ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
